systolic_ctrl: RTL and testbench



---
 rtl/npu_pkg.sv | 19 +
 rtl/systolic_ctrl_counter.sv | 26 ++
 rtl/systolic_ctrl.sv | 162 ++++++++++++++++
 tb/tb_systolic_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU core types: systolic op codes and the tile sequencer state encoding.
package npu_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOP   = 3'd0;
    localparam op_t OP_CLEAR = 3'd1;
    localparam op_t OP_MAC   = 3'd2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/systolic_ctrl_counter.sv
// ctrl_counter: loadable, enabled up-counter with a terminal-count compare.
module ctrl_counter #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic [W-1:0] i_limit,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset)     r_cnt <= '0;
        else if (i_load) r_cnt <= i_load_val;
        else if (i_en)   r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_limit);

endmodule

// File: rtl/systolic_ctrl.sv
// Tile sequencer for the systolic array: clear, stream k_len vectors, drain, write ARRAY_N results.
// Optional SYSTOLIC_CTRL_PERF_CNT_EN adds busy-cycle and write-stall counters.
module systolic_ctrl
    import npu_pkg::*;
#(
    parameter int ARRAY_N      = 16,
    parameter int ARRAY_M      = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int K_WIDTH      = 10,
    parameter int DRAIN_CYCLES = ARRAY_N + ARRAY_M + 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [K_WIDTH-1:0]    k_len,
    input  logic [ADDR_WIDTH-1:0] ibuf_base,
    input  logic [ADDR_WIDTH-1:0] wbuf_base,
    input  logic [ADDR_WIDTH-1:0] obuf_base,
    output logic                  busy,
    output logic                  ibuf_rd_en,
    output logic                  wbuf_rd_en,
    output logic [ADDR_WIDTH-1:0] ibuf_rd_addr,
    output logic [ADDR_WIDTH-1:0] wbuf_rd_addr,
    output logic [2:0]            op_signal,
    output logic                  obuf_wr_en,
    output logic [ADDR_WIDTH-1:0] obuf_wr_addr,
    input  logic                  obuf_wr_ready,
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    output logic [31:0]           perf_cycle_cnt,
    output logic [31:0]           perf_stall_cnt,
`endif
    output logic                  done
);

    localparam int DCW = $clog2(DRAIN_CYCLES + 1);
    localparam int WCW = $clog2(ARRAY_N + 1);

    state_t                r_state;
    op_t                   r_op;
    logic                  r_busy, r_done, r_rd_en, r_wr_en;
    logic [K_WIDTH-1:0]    r_k_len;
    logic [ADDR_WIDTH-1:0] r_ibuf_base, r_wbuf_base, r_obuf_base;

    logic                  w_accept;
    logic [K_WIDTH-1:0]    w_k_cnt;
    logic [DCW-1:0]        w_dr_cnt;
    logic [WCW-1:0]        w_wr_cnt;
    logic                  w_k_tc, w_dr_tc, w_wr_tc, w_wr_fire;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_wr_fire = (r_state == WRITE) && r_wr_en && obuf_wr_ready;

    ctrl_counter #(.W(K_WIDTH)) u_k_cnt (
        .i_clk(clk), .i_reset(reset), .i_load(w_accept), .i_load_val('0),
        .i_en(r_state == STREAM), .i_limit(r_k_len - 1'b1),
        .o_cnt(w_k_cnt), .o_tc(w_k_tc)
    );

    // Counts from DRAIN entry (the last-MAC cycle), so DRAIN_CYCLES full cycles follow that MAC.
    ctrl_counter #(.W(DCW)) u_dr_cnt (
        .i_clk(clk), .i_reset(reset), .i_load(w_accept), .i_load_val('0),
        .i_en(r_state == DRAIN), .i_limit(DCW'(DRAIN_CYCLES)),
        .o_cnt(w_dr_cnt), .o_tc(w_dr_tc)
    );

    ctrl_counter #(.W(WCW)) u_wr_cnt (
        .i_clk(clk), .i_reset(reset), .i_load(w_accept), .i_load_val('0),
        .i_en(w_wr_fire), .i_limit(WCW'(ARRAY_N - 1)),
        .o_cnt(w_wr_cnt), .o_tc(w_wr_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= OP_NOP;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_k_len     <= '0;
            r_ibuf_base <= '0;
            r_wbuf_base <= '0;
            r_obuf_base <= '0;
        end else begin
            r_done <= 1'b0;
            // 1-deep valid delay: MAC lines up with buffer read data.
            r_op   <= r_rd_en ? OP_MAC : OP_NOP;
            case (r_state)
                IDLE: if (start) begin
                    r_k_len     <= k_len;
                    r_ibuf_base <= ibuf_base;
                    r_wbuf_base <= wbuf_base;
                    r_obuf_base <= obuf_base;
                    if (k_len == '0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= CLEAR;
                        r_busy  <= 1'b1;
                        r_op    <= OP_CLEAR;
                    end
                end
                CLEAR: begin
                    r_state <= STREAM;
                    r_rd_en <= 1'b1;
                end
                STREAM: if (w_k_tc) begin
                    r_state <= DRAIN;
                    r_rd_en <= 1'b0;
                end
                DRAIN: if (w_dr_tc) begin
                    r_state <= WRITE;
                    r_wr_en <= 1'b1;
                end
                // Enable drops after the last accepted write; the idle WRITE cycle then hands off to DONE.
                WRITE: begin
                    if (!r_wr_en) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (obuf_wr_ready && w_wr_tc) begin
                        r_wr_en <= 1'b0;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign op_signal    = r_op;
    assign ibuf_rd_en   = r_rd_en;
    assign wbuf_rd_en   = r_rd_en;
    assign ibuf_rd_addr = r_ibuf_base + ADDR_WIDTH'(w_k_cnt);
    assign wbuf_rd_addr = r_wbuf_base + ADDR_WIDTH'(w_k_cnt);
    assign obuf_wr_en   = r_wr_en;
    assign obuf_wr_addr = r_obuf_base + ADDR_WIDTH'(w_wr_cnt);

`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    logic [31:0] r_perf_cyc, r_perf_stall;

    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            r_perf_cyc   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_busy)
                r_perf_cyc <= r_perf_cyc + 32'd1;
            if ((r_state == WRITE) && r_wr_en && !obuf_wr_ready)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_cycle_cnt = r_perf_cyc;
    assign perf_stall_cnt = r_perf_stall;
`else
    // Counters absent in this build.
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl: per-cycle timeline checks of strobes, addresses, op codes and done.
module tb_systolic_ctrl;

    localparam int N  = 16;
    localparam int D  = 36;
    localparam int AW = 10;
    localparam int KW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic [AW-1:0] ibuf_base = '0, wbuf_base = '0, obuf_base = '0;
    logic          obuf_wr_ready = 1'b1;
    logic          busy, done, ibuf_rd_en, wbuf_rd_en, obuf_wr_en;
    logic [AW-1:0] ibuf_rd_addr, wbuf_rd_addr, obuf_wr_addr;
    logic [2:0]    op_signal;

    int n_chk = 0;
    int n_err = 0;
    int cur_c = 0;
    int d_at;

    systolic_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .ibuf_base(ibuf_base), .wbuf_base(wbuf_base), .obuf_base(obuf_base),
        .busy(busy), .ibuf_rd_en(ibuf_rd_en), .wbuf_rd_en(wbuf_rd_en),
        .ibuf_rd_addr(ibuf_rd_addr), .wbuf_rd_addr(wbuf_rd_addr),
        .op_signal(op_signal), .obuf_wr_en(obuf_wr_en), .obuf_wr_addr(obuf_wr_addr),
        .obuf_wr_ready(obuf_wr_ready), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_chk);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cur_c, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " ibuf_rd_en"}, 32'(ibuf_rd_en), 0);
        chk({tag, " wbuf_rd_en"}, 32'(wbuf_rd_en), 0);
        chk({tag, " obuf_wr_en"}, 32'(obuf_wr_en), 0);
        chk({tag, " op"}, 32'(op_signal), 0);
    endtask

    // Start is driven in the current cycle (cycle 0); returns at cycle done+tail.
    task automatic run_tile(input int k, input int ib, input int wb, input int ob,
                            input int st_i, input int st_len, input int sp_c,
                            input int tail, output int done_at);
        int w0, dc, nrd, idx;
        logic          e_rd, e_wr;
        logic [2:0]    e_op;
        logic [AW-1:0] e_a;
        w0 = 3 + k + D;
        dc = (k == 0) ? 1 : w0 + N + st_len + 1;
        nrd = 0;
        done_at = -1;
        k_len = KW'(k);
        ibuf_base = AW'(ib);
        wbuf_base = AW'(wb);
        obuf_base = AW'(ob);
        start = 1'b1;
        for (int c = 1; c <= dc + tail; c++) begin
            step();
            cur_c = c;
            start = (c == sp_c);
            k_len = KW'($urandom);
            ibuf_base = AW'($urandom);
            wbuf_base = AW'($urandom);
            obuf_base = AW'($urandom);
            obuf_wr_ready = !(k > 0 && c >= w0 + st_i && c < w0 + st_i + st_len);
            if (done === 1'b1 && done_at < 0) done_at = c;
            if (ibuf_rd_en === 1'b1) nrd++;
            e_rd = (k > 0 && c >= 2 && c <= 1 + k);
            e_op = (k > 0 && c == 1) ? 3'd1 : (k > 0 && c >= 3 && c <= 2 + k) ? 3'd2 : 3'd0;
            e_wr = (k > 0 && c >= w0 && c < w0 + N + st_len);
            chk("ibuf_rd_en", 32'(ibuf_rd_en), 32'(e_rd));
            chk("wbuf_rd_en", 32'(wbuf_rd_en), 32'(e_rd));
            chk("op_signal", 32'(op_signal), 32'(e_op));
            chk("obuf_wr_en", 32'(obuf_wr_en), 32'(e_wr));
            chk("done", 32'(done), 32'(c == dc));
            chk("busy", 32'(busy), 32'(k > 0 && c < dc));
            if (e_rd) begin
                e_a = AW'(ib + c - 2);
                chk("ibuf_rd_addr", 32'(ibuf_rd_addr), 32'(e_a));
                e_a = AW'(wb + c - 2);
                chk("wbuf_rd_addr", 32'(wbuf_rd_addr), 32'(e_a));
            end
            if (e_wr) begin
                if (c < w0 + st_i)               idx = c - w0;
                else if (c < w0 + st_i + st_len) idx = st_i;
                else                             idx = c - w0 - st_len;
                e_a = AW'(ob + idx);
                chk("obuf_wr_addr", 32'(obuf_wr_addr), 32'(e_a));
            end
        end
        start = 1'b0;
        obuf_wr_ready = 1'b1;
        chk("rd_count", 32'(nrd), 32'(k));
    endtask

    initial begin
        reset = 1'b1;
        step(); step(); step();
        chk_idle("reset");
        chk("reset ibuf_rd_addr", 32'(ibuf_rd_addr), 0);
        chk("reset obuf_wr_addr", 32'(obuf_wr_addr), 0);
        reset = 1'b0;
        step();

        run_tile(4, 'h10, 'h20, 'h30, 0, 0, 0, 2, d_at);
        chk("normal done cycle", 32'(d_at), 60);

        run_tile(0, 'h10, 'h20, 'h30, 0, 0, 0, 3, d_at);
        chk("zero-len done cycle", 32'(d_at), 1);

        run_tile(4, 'h10, 'h20, 'h30, 5, 3, 0, 2, d_at);
        chk("stall done cycle", 32'(d_at), 63);

        run_tile(4, 'h3FE, 'h3FD, 'h3FC, 0, 0, 0, 2, d_at);
        chk("wrap done cycle", 32'(d_at), 60);

        // Start pulse during DRAIN must be ignored.
        run_tile(3, 'h40, 'h50, 'h60, 0, 0, 20, 4, d_at);
        chk("busy-start done cycle", 32'(d_at), 59);

        // Stall on the final write, then a back-to-back tile right after done.
        run_tile(1, 'h000, 'h001, 'h100, 15, 2, 0, 1, d_at);
        chk("last-stall done cycle", 32'(d_at), 59);
        run_tile(2, 'h0AA, 'h0BB, 'h0CC, 0, 0, 0, 2, d_at);
        chk("b2b done cycle", 32'(d_at), 58);

        // Reset in the middle of STREAM aborts the tile.
        k_len = KW'(8);
        ibuf_base = AW'('h100);
        wbuf_base = AW'('h200);
        obuf_base = AW'('h300);
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        cur_c = 4;
        chk("pre-abort ibuf_rd_en", 32'(ibuf_rd_en), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cur_c = 5;
        chk_idle("abort");
        chk("abort ibuf_rd_addr", 32'(ibuf_rd_addr), 0);
        chk("abort wbuf_rd_addr", 32'(wbuf_rd_addr), 0);
        chk("abort obuf_wr_addr", 32'(obuf_wr_addr), 0);
        step(); step();
        cur_c = 7;
        chk_idle("post-abort");
        run_tile(4, 'h10, 'h20, 'h30, 0, 0, 0, 2, d_at);
        chk("post-abort done cycle", 32'(d_at), 60);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
